// File: rtl/fft_frame_receiver_pkg.sv
// Shared types and width helpers for the FFT result receiver and the FFT core.
package fft_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } rx_state_e;

  localparam int DW_DEF = 8;

  function automatic int pw_f(input int dw);
    return 2 * dw + 1;
  endfunction

  function automatic int aw_f(input int n);
    return $clog2(n);
  endfunction

  // Bin word layout on the FFT output bus: I in the upper half, Q in the lower half.
  function automatic logic [2*DW_DEF-1:0] iq_pack(input logic signed [DW_DEF-1:0] i,
                                                  input logic signed [DW_DEF-1:0] q);
    return {i, q};
  endfunction

  function automatic logic signed [DW_DEF-1:0] iq_get_i(input logic [2*DW_DEF-1:0] w);
    return w[2*DW_DEF-1:DW_DEF];
  endfunction

  function automatic logic signed [DW_DEF-1:0] iq_get_q(input logic [2*DW_DEF-1:0] w);
    return w[DW_DEF-1:0];
  endfunction

endpackage

// File: rtl/fft_frame_receiver_power_calc.sv
// Square-and-sum pipeline: S1 registers I/Q, S2 registers the squares, S3 sum is presented
// combinationally so the top can write the RAM and update the peak on the same edge.
module fft_power_calc
  import fft_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 6,
  localparam int PW        = pw_f(DATA_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    valid_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  input  logic [AW-1:0]           bin_i,
  input  logic                    bank_i,
  input  logic                    last_i,
  output logic                    valid_o,
  output logic [AW-1:0]           bin_o,
  output logic                    bank_o,
  output logic                    last_o,
  output logic [PW-1:0]           power_o
);

  localparam int SW = 2 * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0] i_q, q_q;
  logic [SW-1:0]                sq_i_q, sq_q_q;
  logic [AW-1:0]                bin1_q, bin2_q;
  logic                         bank1_q, bank2_q, last1_q, last2_q, v1_q, v2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  // Squares of a signed DW value always fit in 2*DW bits, including (-2^(DW-1))^2.
  always_ff @(posedge clk_i) begin
    i_q     <= data_i[SW-1:DATA_WIDTH];
    q_q     <= data_i[DATA_WIDTH-1:0];
    bin1_q  <= bin_i;
    bank1_q <= bank_i;
    last1_q <= last_i;
    sq_i_q  <= SW'(i_q) * SW'(i_q);
    sq_q_q  <= SW'(q_q) * SW'(q_q);
    bin2_q  <= bin1_q;
    bank2_q <= bank1_q;
    last2_q <= last1_q;
  end

  assign valid_o = v2_q;
  assign bin_o   = bin2_q;
  assign bank_o  = bank2_q;
  assign last_o  = last2_q;
  assign power_o = PW'(sq_i_q) + PW'(sq_q_q);

endmodule

// File: rtl/fft_frame_receiver.sv
// Captures one N-bin FFT frame, stores per-bin power in a ping-pong buffer and reports the peak.
module fft_frame_receiver
  import fft_frame_receiver_pkg::*;
#(
  parameter int N          = 64,
  parameter int DATA_WIDTH = 8,
  localparam int AW        = aw_f(N),
  localparam int PW        = pw_f(DATA_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    in_valid_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  output logic                    frame_done_o,
  output logic [AW-1:0]           peak_bin_o,
  output logic [PW-1:0]           peak_power_o,
  output logic                    err_short_o,
  output logic                    busy_o,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [PW-1:0]           rd_data_o
);

  rx_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wbank_q, wbank_d;
  logic          err_q, err_d;
  logic          last_word;

  logic          p_valid, p_bank, p_last;
  logic [AW-1:0] p_bin;
  logic [PW-1:0] p_power;

  logic [PW-1:0] max_q, peak_power_q, rd_q;
  logic [AW-1:0] maxbin_q, peak_bin_q;
  logic          commit_q, commit_bank_q, done_q, rbank_q;
  logic [PW-1:0] mem0_q [N];
  logic [PW-1:0] mem1_q [N];

  assign last_word = in_valid_i && (cnt_q == AW'(N - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // DRAIN exits on the commit edge unless the next frame has already started.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = CAPTURE;
      CAPTURE: if (!in_valid_i) state_d = IDLE;
               else if (last_word) state_d = DRAIN;
      DRAIN:   if (in_valid_i) state_d = CAPTURE;
               else if (commit_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    wbank_d = wbank_q;
    err_d   = 1'b0;
    if (state_q == CAPTURE && !in_valid_i) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else if (in_valid_i) begin
      if (last_word) begin
        cnt_d   = '0;
        wbank_d = ~wbank_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      wbank_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wbank_q <= wbank_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign err_short_o = err_q;

  fft_power_calc #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_power (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (in_valid_i),
    .data_i  (in_data_i),
    .bin_i   (cnt_q),
    .bank_i  (wbank_q),
    .last_i  (last_word),
    .valid_o (p_valid),
    .bin_o   (p_bin),
    .bank_o  (p_bank),
    .last_o  (p_last),
    .power_o (p_power)
  );

  // Strict compare keeps the lowest bin on ties; bin 0 restarts the running max.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      max_q         <= '0;
      maxbin_q      <= '0;
      commit_q      <= 1'b0;
      commit_bank_q <= 1'b0;
    end else begin
      commit_q      <= p_valid && p_last;
      commit_bank_q <= p_bank;
      if (p_valid && (p_bin == '0 || p_power > max_q)) begin
        max_q    <= p_power;
        maxbin_q <= p_bin;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (p_valid && !p_bank) mem0_q[p_bin] <= p_power;
    if (p_valid && p_bank)  mem1_q[p_bin] <= p_power;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      done_q       <= 1'b0;
      peak_bin_q   <= '0;
      peak_power_q <= '0;
      rbank_q      <= 1'b0;
      rd_q         <= '0;
    end else begin
      done_q <= commit_q;
      if (commit_q) begin
        peak_bin_q   <= maxbin_q;
        peak_power_q <= max_q;
        rbank_q      <= commit_bank_q;
      end
      rd_q <= rbank_q ? mem1_q[rd_addr_i] : mem0_q[rd_addr_i];
    end
  end

  assign frame_done_o = done_q;
  assign peak_bin_o   = peak_bin_q;
  assign peak_power_o = peak_power_q;
  assign rd_data_o    = rd_q;

endmodule

// File: tb/tb_fft_frame_receiver.sv
// Bench for fft_frame_receiver (N=8, DW=8): frame-level model checked every cycle plus literal checks.
module tb_fft_frame_receiver;
  import fft_frame_receiver_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int PW = 17;

  logic          clk = 1'b0;
  logic          rst_n, in_valid;
  logic [15:0]   in_data;
  logic [AW-1:0] rd_addr;
  logic          frame_done, err_short, busy;
  logic [AW-1:0] peak_bin;
  logic [PW-1:0] peak_power, rd_data;

  always #5 clk = ~clk;

  fft_frame_receiver #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .frame_done_o (frame_done),
    .peak_bin_o   (peak_bin),
    .peak_power_o (peak_power),
    .err_short_o  (err_short),
    .busy_o       (busy),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data)
  );

  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic cmp(input string nm, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: collect powers per frame, schedule the commit 3 edges after the last word.
  int  cyc = 0;
  int  cnt = 0;
  int  cur [N];
  int  rframe [N];
  int  pend_frame [N];
  bit  have_frame = 0;
  bit  pend_v = 0;
  int  pend_due, pend_bin, pend_pow;
  bit  e_done = 0, e_err = 0, e_busy = 0, e_rd_chk = 0;
  int  e_pbin = 0, e_ppow = 0, e_rd = 0;
  bit  chk_en = 0;

  initial begin
    int ii, qq, best, bb;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        cnt = 0; pend_v = 0; have_frame = 0;
        e_done = 0; e_err = 0; e_busy = 0; e_pbin = 0; e_ppow = 0; e_rd = 0; e_rd_chk = 1;
      end else begin
        e_done = 0;
        e_err  = 0;
        e_rd_chk = have_frame;
        if (have_frame) e_rd = rframe[rd_addr];
        if (pend_v && pend_due == cyc) begin
          e_done = 1; e_pbin = pend_bin; e_ppow = pend_pow;
          rframe = pend_frame; have_frame = 1; pend_v = 0;
        end
        if (in_valid) begin
          ii = iq_get_i(in_data);
          qq = iq_get_q(in_data);
          cur[cnt] = ii * ii + qq * qq;
          cnt++;
          if (cnt == N) begin
            best = 0; bb = 0;
            for (int b = 0; b < N; b++)
              if (b == 0 || cur[b] > best) begin best = cur[b]; bb = b; end
            pend_v = 1; pend_due = cyc + 3; pend_bin = bb; pend_pow = best;
            pend_frame = cur; cnt = 0;
          end
        end else if (cnt > 0) begin
          e_err = 1;
          cnt = 0;
        end
        e_busy = (cnt > 0) || pend_v;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("frame_done", frame_done, e_done);
        cmp("err_short", err_short, e_err);
        cmp("busy", busy, e_busy);
        cmp("peak_bin", peak_bin, e_pbin);
        cmp("peak_power", peak_power, e_ppow);
        if (e_rd_chk) cmp("rd_data", rd_data, e_rd);
      end
    end
  end

  int fi [N];
  int fq [N];

  task automatic step(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000);
  endtask

  task automatic send_words(input int nw);
    for (int b = 0; b < nw; b++) step(1'b1, iq_pack(8'(fi[b]), 8'(fq[b])));
  endtask

  task automatic set_frame(input int i_all, input int q_all);
    for (int b = 0; b < N; b++) begin fi[b] = i_all; fq[b] = q_all; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, t, d1, d2, pb1, pp1, pb2, pp2, pulses;
    rst_n = 0; in_valid = 0; in_data = 0; rd_addr = 0;

    // 1: reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      chk_en = 1;
    end
    cmp("rst_busy", busy, 0);
    cmp("rst_peak_power", peak_power, 0);
    cmp("rst_rd_data", rd_data, 0);
    rst_n = 1;
    idle(2);

    // 2: single nonzero bin
    set_frame(0, 0);
    fi[3] = 10; fq[3] = -5;
    send_words(N);
    lat = 0;
    for (int w = 1; w <= 6 && lat == 0; w++) begin
      step(1'b0, 16'h0000);
      if (frame_done) lat = w;
    end
    cmp("done_latency", lat, 3);
    cmp("t2_peak_bin", peak_bin, 3);
    cmp("t2_peak_power", peak_power, 125);
    rd_addr = 3;
    idle(1);
    cmp("t2_rd_bin3", rd_data, 125);
    rd_addr = 0;
    idle(1);
    cmp("t2_rd_bin0", rd_data, 0);

    // 3: tie resolves to lowest bin
    set_frame(1, 0);
    fi[2] = 5; fq[2] = 5; fi[5] = 5; fq[5] = 5;
    send_words(N);
    idle(4);
    cmp("t3_peak_bin", peak_bin, 2);
    cmp("t3_peak_power", peak_power, 50);

    // 4: short frame
    for (int b = 0; b < N; b++) begin fi[b] = b + 1; fq[b] = 2; end
    send_words(5);
    idle(1);
    cmp("t4_err_pulse", err_short, 1);
    pulses = 0;
    for (int w = 0; w < 5; w++) begin
      idle(1);
      if (frame_done) pulses++;
    end
    cmp("t4_no_done", pulses, 0);
    cmp("t4_peak_bin", peak_bin, 2);
    cmp("t4_peak_power", peak_power, 50);
    rd_addr = 5;
    idle(1);
    cmp("t4_rd_prior", rd_data, 50);

    // 5: back-to-back frames
    t = 0; d1 = -1; d2 = -1; pb1 = 0; pp1 = 0; pb2 = 0; pp2 = 0;
    rd_addr = 5;
    for (int k = 0; k < 2 * N + 8; k++) begin
      if (k < N)            step(1'b1, iq_pack(8'(k), 8'(0)));
      else if (k < 2 * N)   step(1'b1, iq_pack(8'(-(k - N)), 8'(-(k - N))));
      else                  step(1'b0, 16'h0000);
      t++;
      if (k == 12) cmp("t5_rd_frame1", rd_data, 25);
      if (frame_done) begin
        if (d1 < 0) begin d1 = t; pb1 = peak_bin; pp1 = peak_power; end
        else begin d2 = t; pb2 = peak_bin; pp2 = peak_power; end
      end
    end
    cmp("t5_done_spacing", d2 - d1, 8);
    cmp("t5_peak1_bin", pb1, 7);
    cmp("t5_peak1_power", pp1, 49);
    cmp("t5_peak2_bin", pb2, 7);
    cmp("t5_peak2_power", pp2, 98);

    // 6: extreme value, then reset mid-frame
    set_frame(0, 0);
    fi[6] = -128; fq[6] = -128;
    send_words(N);
    idle(4);
    cmp("t6_peak_bin", peak_bin, 6);
    cmp("t6_peak_power", peak_power, 32768);
    send_words(4);
    rst_n = 0;
    step(1'b1, iq_pack(8'(3), 8'(3)));
    rst_n = 1;
    pulses = 0;
    for (int w = 0; w < 6; w++) begin
      idle(1);
      if (frame_done || err_short) pulses++;
    end
    cmp("t6_no_pulses", pulses, 0);
    cmp("t6_peak_power_rst", peak_power, 0);
    cmp("t6_peak_bin_rst", peak_bin, 0);
    cmp("t6_busy_rst", busy, 0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
